ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 102 ++++++++++
 tb/tb_ram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port asynchronous RAM.
// Each granted request takes three cycles: IDLE (arbitrate), ACCESS (drive RAM), RESP (ack + data).
module ram_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_writeOn,
    input  logic [DW-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q;
    logic          prio_q;
    logic          owner_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          busy_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] ram_address_q;
    logic [DW-1:0] ram_data_in_q;
    logic          ram_writeOn_q;
    logic          grant1_d;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign grant1_d = req1 & (~req0 | prio_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
            ram_address_q <= '0;
            ram_data_in_q <= '0;
            ram_writeOn_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 | req1) begin
                        state_q       <= ACCESS;
                        busy_q        <= 1'b1;
                        owner_q       <= grant1_d;
                        ram_address_q <= grant1_d ? addr1 : addr0;
                        ram_data_in_q <= grant1_d ? wdata1 : wdata0;
                        ram_writeOn_q <= grant1_d ? we1 : we0;
                    end
                end
                ACCESS: begin
                    // RAM is asynchronous: its output already reflects this cycle's address.
                    state_q       <= RESP;
                    ram_writeOn_q <= 1'b0;
                    rdata_q       <= ram_data_out;
                    ack0_q        <= ~owner_q;
                    ack1_q        <= owner_q;
                    prio_q        <= ~owner_q;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign ram_address = ram_address_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_writeOn = ram_writeOn_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, ram_writeOn;
    logic [31:0] rdata, ram_data_in, ram_data_out;
    logic [4:0]  ram_address;

    int vectors = 0;
    int miscompares = 0;

    // Asynchronous RAM: write lands while writeOn is high, read sees it in the same cycle.
    logic [31:0] mem [32];
    always @(posedge clk) if (ram_writeOn) mem[ram_address] <= ram_data_in;
    assign ram_data_out = ram_writeOn ? ram_data_in : mem[ram_address];

    // Reference model: memory contents and which requester wins a tie next.
    logic [31:0] ref_mem [32];
    bit          ref_pref = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_writeOn(ram_writeOn), .ram_data_out(ram_data_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_winner(bit r0, bit r1);
        if (r0 && r1) return ref_pref ? 1 : 0;
        return r0 ? 0 : 1;
    endfunction

    // Drives held requests until an ack arrives; the winner drops its request.
    task automatic run_txn(output int who, output logic [31:0] rd, output logic [4:0] acc_addr,
                           output int wr_cycles, output int lat);
        who = -1; rd = '0; acc_addr = '0; wr_cycles = 0; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ram_writeOn) wr_cycles++;
            if (busy && !ack0 && !ack1) acc_addr = ram_address;
            if (ack0 || ack1) begin
                who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                rd = rdata;
                lat = i;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %0b%0b exp 00", ack0, ack1); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        vectors++; if (ram_address !== 5'd0 || ram_data_in !== 32'h0 || ram_writeOn !== 1'b0) begin
            miscompares++; $display("FAIL reset_ram got a=%0d d=%h w=%0b exp 0/0/0", ram_address, ram_data_in, ram_writeOn); end
        rst = 1'b0;
        ref_pref = 1'b0;
    endtask

    task automatic test_single_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        vectors++; if (ram_writeOn !== 1'b1 || ram_address !== 5'd5 || ram_data_in !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL wr_access got w=%0b a=%0d d=%h exp 1/5/deadbeef", ram_writeOn, ram_address, ram_data_in); end
        vectors++; if (busy !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            miscompares++; $display("FAIL wr_access_ctl got busy=%0b ack=%0b%0b exp 1/00", busy, ack0, ack1); end
        tick();
        vectors++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_writeOn !== 1'b0) begin
            miscompares++; $display("FAIL wr_resp got ack=%0b%0b w=%0b exp 10/0", ack0, ack1, ram_writeOn); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_rdata got %h exp deadbeef", rdata); end
        req0 = 1'b0; we0 = 1'b0;
        tick();
        vectors++; if (ack0 !== 1'b0 || busy !== 1'b0 || ram_writeOn !== 1'b0 || ram_address !== 5'd5) begin
            miscompares++; $display("FAIL wr_idle got ack0=%0b busy=%0b w=%0b a=%0d exp 0/0/0/5", ack0, busy, ram_writeOn, ram_address); end
        ref_mem[5] = 32'hDEADBEEF;
        ref_pref = 1'b1;
    endtask

    task automatic test_read_after_write();
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
        tick();
        vectors++; if (ram_writeOn !== 1'b0 || ram_address !== 5'd5 || busy !== 1'b1) begin
            miscompares++; $display("FAIL rd_access got w=%0b a=%0d busy=%0b exp 0/5/1", ram_writeOn, ram_address, busy); end
        tick();
        vectors++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || ram_writeOn !== 1'b0) begin
            miscompares++; $display("FAIL rd_resp got ack=%0b%0b w=%0b exp 01/0", ack0, ack1, ram_writeOn); end
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_rdata got %h exp deadbeef", rdata); end
        req1 = 1'b0;
        tick();
        vectors++; if (ack1 !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rd_idle got ack1=%0b busy=%0b exp 0/0", ack1, busy); end
        ref_pref = 1'b0;
    endtask

    task automatic test_contention();
        int grants;
        int exp_who;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
        tick();
        rst = 1'b0;
        ref_pref = 1'b0;
        grants = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_who = grants % 2;
            case ((i - 1) % 3)
                0: begin
                    vectors++; if (ram_address !== (exp_who == 1 ? 5'd2 : 5'd1) || busy !== 1'b1) begin
                        miscompares++; $display("FAIL cont_addr[%0d] got a=%0d busy=%0b exp %0d/1", i, ram_address, busy, exp_who + 1); end
                end
                1: begin
                    vectors++; if (ack0 !== (exp_who == 0) || ack1 !== (exp_who == 1)) begin
                        miscompares++; $display("FAIL cont_ack[%0d] got %0b%0b exp owner %0d", i, ack0, ack1, exp_who); end
                    vectors++; if (rdata !== ref_mem[exp_who + 1]) begin
                        miscompares++; $display("FAIL cont_rdata[%0d] got %h exp %h", i, rdata, ref_mem[exp_who + 1]); end
                    grants++;
                end
                default: begin
                    vectors++; if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
                        miscompares++; $display("FAIL cont_idle[%0d] got busy=%0b ack=%0b%0b exp 0/00", i, busy, ack0, ack1); end
                end
            endcase
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_pref = 1'b0;
    endtask

    task automatic test_pointer();
        int who, wc, lat;
        logic [31:0] rd;
        logic [4:0] aa;
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd9;
        run_txn(who, rd, aa, wc, lat);
        vectors++; if (who !== 0 || lat !== 2) begin miscompares++; $display("FAIL ptr_lone0 got who=%0d lat=%0d exp 0/2", who, lat); end
        ref_pref = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd10;
        run_txn(who, rd, aa, wc, lat);
        vectors++; if (who !== 1 || lat !== 3) begin miscompares++; $display("FAIL ptr_lone1 got who=%0d lat=%0d exp 1/3", who, lat); end
        ref_pref = 1'b0;
        req0 = 1'b1; addr0 = 5'd11; req1 = 1'b1; addr1 = 5'd12;
        run_txn(who, rd, aa, wc, lat);
        vectors++; if (who !== model_winner(1'b1, 1'b1) || aa !== 5'd11) begin
            miscompares++; $display("FAIL ptr_both_first got who=%0d a=%0d exp 0/11", who, aa); end
        ref_pref = 1'b1;
        run_txn(who, rd, aa, wc, lat);
        vectors++; if (who !== 1 || aa !== 5'd12 || lat !== 3) begin
            miscompares++; $display("FAIL ptr_both_second got who=%0d a=%0d lat=%0d exp 1/12/3", who, aa, lat); end
        ref_pref = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 32'h12345678;
        tick();
        vectors++; if (ram_writeOn !== 1'b1 || ram_address !== 5'd7) begin
            miscompares++; $display("FAIL rstacc_drive got w=%0b a=%0d exp 1/7", ram_writeOn, ram_address); end
        rst = 1'b1; req0 = 1'b0; we0 = 1'b0;
        tick();
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0 ||
                       ram_address !== 5'd0 || ram_data_in !== 32'h0 || ram_writeOn !== 1'b0) begin
            miscompares++; $display("FAIL rstacc_outputs got ack=%0b%0b busy=%0b rd=%h a=%0d d=%h w=%0b exp all 0",
                                    ack0, ack1, busy, rdata, ram_address, ram_data_in, ram_writeOn); end
        rst = 1'b0;
        ref_mem[7] = 32'h12345678;
        ref_pref = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
        tick(); tick();
        vectors++; if (ack1 !== 1'b1 || rdata !== 32'h12345678) begin
            miscompares++; $display("FAIL rstacc_readback got ack1=%0b rd=%h exp 1/12345678", ack1, rdata); end
        rst = 1'b1; req1 = 1'b0;
        tick();
        vectors++; if (ack1 !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rstresp_drop got ack1=%0b rd=%h busy=%0b exp 0/0/0", ack1, rdata, busy); end
        rst = 1'b0;
        ref_pref = 1'b0;
    endtask

    task automatic test_late_drop();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
        for (int i = 1; i <= 6; i++) begin
            tick();
            vectors++; if (busy !== (i % 3 != 0) || ack0 !== (i % 3 == 2) || ack1 !== 1'b0) begin
                miscompares++; $display("FAIL late_drop[%0d] got busy=%0b ack=%0b%0b exp %0b/%0b0", i, busy, ack0, ack1, i % 3 != 0, i % 3 == 2); end
            if (i % 3 == 1) begin
                vectors++; if (ram_address !== 5'd3) begin miscompares++; $display("FAIL late_addr[%0d] got %0d exp 3", i, ram_address); end
            end
        end
        req0 = 1'b0;
        ref_pref = 1'b1;
    endtask

    task automatic test_random();
        int who, wc, lat, exp_who, exp_lat;
        logic [31:0] rd, exp_rd, exp_wd;
        logic [4:0] aa, exp_a;
        bit exp_we;
        for (int r = 0; r < 40; r++) begin
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = 5'($urandom_range(0, 31)); wdata1 = $urandom;
            end
            if (!req0 && !req1) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = 5'($urandom_range(0, 31)); wdata0 = $urandom;
            end
            exp_who = model_winner(req0, req1);
            exp_we  = (exp_who == 1) ? we1 : we0;
            exp_a   = (exp_who == 1) ? addr1 : addr0;
            exp_wd  = (exp_who == 1) ? wdata1 : wdata0;
            exp_rd  = exp_we ? exp_wd : ref_mem[exp_a];
            exp_lat = (r == 0) ? 2 : 3;
            run_txn(who, rd, aa, wc, lat);
            vectors++; if (who !== exp_who) begin miscompares++; $display("FAIL rand_owner[%0d] got %0d exp %0d", r, who, exp_who); end
            vectors++; if (rd !== exp_rd || aa !== exp_a) begin
                miscompares++; $display("FAIL rand_data[%0d] got rd=%h a=%0d exp %h/%0d", r, rd, aa, exp_rd, exp_a); end
            vectors++; if (wc !== int'(exp_we) || lat !== exp_lat) begin
                miscompares++; $display("FAIL rand_timing[%0d] got wr=%0d lat=%0d exp %0d/%0d", r, wc, lat, exp_we, exp_lat); end
            if (exp_we) ref_mem[exp_a] = exp_wd;
            ref_pref = (exp_who == 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_single_write();
        test_read_after_write();
        test_contention();
        test_pointer();
        test_reset_mid();
        test_late_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
